fsm_trace_monitor: RTL and testbench
====================================

# fsm_trace_monitor

Checker stage directly downstream of the five-state sequence FSM (states 2, 4, 5, 6, 7; input `a`; 3-bit state output). The block watches the same `a` the FSM sees and the FSM's 3-bit state output every clock. It recomputes the legal successor internally and flags the first illegal code, wrong transition or bad post-reset state. It also keeps saturating counters of checked transitions and of entries into a watched state, for bench and debug visibility.

## Interface
- `CNT_W`, 8: width of both counters.
- `WATCH`, 3'd7: state code whose entries are counted.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `a`  in  1  the FSM's input, the same net and cycle the FSM samples.
- `s`  in  3  the FSM's current state output.
- `err`  out  1  sticky error flag.
- `err_code`  out  2  meaning of the latched error:
  - 00: none
  - 01: illegal code
  - 10: wrong transition
  - 11: bad reset state
- `err_got`  out  3  value of `s` at the latched error.
- `err_exp`  out  3  expected value at the latched error (3'd2 for code 11; 0 for code 01).
- `trans_cnt`  out  CNT_W  checked transitions, saturating.
- `hit_cnt`  out  CNT_W  entries into `WATCH`, saturating.

## Operation
- Successor function nxt(p, a):
  - 2→4
  - 4→(a ? 7 : 6)
  - 5→(a ? 4 : 2)
  - 6→5
  - 7→6
  - codes 0, 1, 3 → same code (hold)
- Internal registers: `prev_s[2:0]`, `prev_a`, `phase[1:0]`.
- Phase state machine:
  - `IDLE`: entered on reset. On the next edge, check `s==3'd2`, else raise code 11. Load `prev_s`/`prev_a`, go to `RUN`.
  - `RUN`: every edge, compute exp = nxt(prev_s, prev_a) and check in this priority order:
    1. `s` in {0, 1, 3} → code 01.
    2. Otherwise `s != exp` → code 10.
  - In `RUN`, also increment `trans_cnt` on every edge, and reload `prev_s`/`prev_a` every edge.
- Error latch: the first error sets `err=1` and captures `err_code`, `err_got`, `err_exp`. Later errors do not overwrite the capture. Only `reset` clears it.
- Checking and counting continue after an error.
- `hit_cnt` increments when `s==WATCH` and (phase is `IDLE` or `prev_s!=WATCH`). An entry is a change into WATCH, not dwell.
- Counters saturate at 2^CNT_W−1; no wrap.
- An `IDLE` check with `s` illegal (0, 1, 3) reports code 11, not 01.

## Timing
- Reset values: `err=0`, `err_code=00`, `err_got=0`, `err_exp=0`, `trans_cnt=0`, `hit_cnt=0`, phase=`IDLE`.
- Reset has priority over every check in the same cycle.
- Latency:
  - A wrong state presented at edge k is reported in `err` and the capture fields immediately after edge k (one registered stage).
  - The transition checked at edge k is the one the FSM made at edge k−1 using `a` at edge k−1.
- The first check in `RUN` happens at the second edge after `reset` deasserts.
- Reset asserted mid-run: the next edge clears everything and returns to `IDLE`. No check is made on that edge.
- Simultaneous illegal code and mismatch: report code 01.
- Counter at max plus an increment condition: the counter holds its value.

## Structure
- Shared package holds:
  - state code constants S2, S4, S5, S6, S7 (3'd2, 3'd4, 3'd5, 3'd6, 3'd7)
  - `err_code` constants
  - the nxt() function, so the FSM, this checker and the bench agree on one definition
- One sub-module is natural: `sat_counter` (parameter W; ports `clk`, `reset`, `inc`, `q`), instantiated twice.

## Test plan
- Reset, then drive `s`=2, 4, 6, 5, 2, 4 with `a`=0 throughout → `err=0`; `trans_cnt`=5; `hit_cnt`=0 with WATCH=7.
- `a`=1 path: `s`=2, 4, 7, 6, 5, 4, 7 with `a` held 1 → `err=0`; `hit_cnt`=2 (two entries into 7); `trans_cnt`=6.
- From `s`=4 with `a`=0, present `s`=7 next cycle → `err=1`, `err_code=10`, `err_got=7`, `err_exp=6`. A later illegal code leaves the capture unchanged.
- In `RUN`, present `s`=3 → `err_code=01`, `err_got=3`, `err_exp=0`.
  - Separately: first sample after reset `s`=5 → `err_code=11`, `err_exp=2`.
- CNT_W=3, run the legal 2→4→6→5→2 loop for 20 cycles → `trans_cnt` saturates at 7 and holds.
- Assert `reset` mid-run after an error → next cycle all outputs are 0 and phase is `IDLE`. With `s`=2 on the following edge, checking resumes cleanly.

Source files
------------

// File: rtl/fsm_trace_monitor_pkg.sv
// Shared definitions for the five-state sequence FSM and its trace monitor.
// Holds the legal state codes, the error code values, the phase encoding
// of the monitor, and the successor function nxt(), the single definition
// of the FSM's legal behaviour.
package fsm_trace_monitor_pkg;

    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [2:0] S5 = 3'd5;
    localparam logic [2:0] S6 = 3'd6;
    localparam logic [2:0] S7 = 3'd7;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL   = 2'b01;
    localparam logic [1:0] ERR_WRONG     = 2'b10;
    localparam logic [1:0] ERR_BAD_RESET = 2'b11;

    typedef enum logic [1:0] {
        PhaseIdle = 2'd0,
        PhaseRun  = 2'd1
    } phase_e;

    // Legal successor of state p when the FSM samples input a.
    // Codes outside the five legal states hold their value.
    function automatic logic [2:0] nxt(input logic [2:0] p, input logic a);
        logic [2:0] r;
        r = p;
        case (p)
            S2:      r = S4;
            S4:      r = a ? S7 : S6;
            S5:      r = a ? S4 : S2;
            S6:      r = S5;
            S7:      r = S6;
            default: r = p;
        endcase
        return r;
    endfunction

    function automatic logic is_illegal(input logic [2:0] p);
        return (p == 3'd0) || (p == 3'd1) || (p == 3'd3);
    endfunction

endpackage

// File: rtl/fsm_trace_monitor_if.sv
// Bundle between the observed FSM and the trace monitor.
//   a, s        : FSM input and state output (driven by the FSM side)
//   err*        : sticky error flag and the capture of the first error
//   trans_cnt   : saturating count of checked transitions
//   hit_cnt     : saturating count of entries into the watched state
// Modports: master = FSM/observer side, slave = monitor side.
interface fsm_trace_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    logic             a;
    logic [2:0]       s;
    logic             err;
    logic [1:0]       err_code;
    logic [2:0]       err_got;
    logic [2:0]       err_exp;
    logic [CNT_W-1:0] trans_cnt;
    logic [CNT_W-1:0] hit_cnt;

    modport master (
        output a, s,
        input  err, err_code, err_got, err_exp, trans_cnt, hit_cnt
    );

    modport slave (
        input  a, s,
        output err, err_code, err_got, err_exp, trans_cnt, hit_cnt
    );
endinterface

// File: rtl/fsm_trace_monitor_sat_counter.sv
// Saturating up-counter.
//   clk   : clock
//   reset : synchronous active-high clear
//   inc   : increment request; ignored once the counter reaches all ones
//   q     : current count
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end
endmodule

// File: rtl/fsm_trace_monitor.sv
// Trace monitor for the five-state sequence FSM (states 2, 4, 5, 6, 7).
// Watches the FSM input a and state output s every clock, recomputes the
// legal successor and latches the first illegal code, wrong transition or
// bad post-reset state. Also counts checked transitions and entries into
// state WATCH, both saturating.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset, overrides every check
//   bus   : slave modport carrying a, s in and err/err_code/err_got/
//           err_exp/trans_cnt/hit_cnt out
module fsm_trace_monitor
    import fsm_trace_monitor_pkg::*;
#(
    parameter int unsigned CNT_W = 8,
    parameter logic [2:0]  WATCH = 3'd7
) (
    input  logic                clk,
    input  logic                reset,
    fsm_trace_monitor_if.slave  bus
);
    phase_e     phase_q, phase_d;
    logic [2:0] prev_s_q;
    logic       prev_a_q;

    logic       err_q, err_d;
    logic [1:0] code_q, code_d;
    logic [2:0] got_q, got_d;
    logic [2:0] exp_q, exp_d;

    logic       chk_fail;
    logic [1:0] chk_code;
    logic [2:0] chk_exp;
    logic [2:0] succ;
    logic       trans_inc;
    logic       hit_inc;

    assign succ = nxt(prev_s_q, prev_a_q);

    always_comb begin
        phase_d   = phase_q;
        chk_fail  = 1'b0;
        chk_code  = ERR_NONE;
        chk_exp   = 3'd0;
        trans_inc = 1'b0;

        case (phase_q)
            PhaseIdle: begin
                // First sample after reset must be S2; illegal codes here
                // are reported as a bad reset state, not as illegal.
                if (bus.s != S2) begin
                    chk_fail = 1'b1;
                    chk_code = ERR_BAD_RESET;
                    chk_exp  = S2;
                end
                phase_d = PhaseRun;
            end
            PhaseRun: begin
                trans_inc = 1'b1;
                if (is_illegal(bus.s)) begin
                    chk_fail = 1'b1;
                    chk_code = ERR_ILLEGAL;
                    chk_exp  = 3'd0;
                end else if (bus.s != succ) begin
                    chk_fail = 1'b1;
                    chk_code = ERR_WRONG;
                    chk_exp  = succ;
                end
            end
            default: phase_d = PhaseIdle;
        endcase

        // Entry into WATCH, not dwell: prev_s is meaningless in idle.
        hit_inc = (bus.s == WATCH) && ((phase_q == PhaseIdle) || (prev_s_q != WATCH));
    end

    // Only the first error is captured; later ones leave the latch alone.
    always_comb begin
        err_d  = err_q;
        code_d = code_q;
        got_d  = got_q;
        exp_d  = exp_q;
        if (chk_fail && !err_q) begin
            err_d  = 1'b1;
            code_d = chk_code;
            got_d  = bus.s;
            exp_d  = chk_exp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q  <= PhaseIdle;
            prev_s_q <= 3'd0;
            prev_a_q <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
            got_q    <= 3'd0;
            exp_q    <= 3'd0;
        end else begin
            phase_q  <= phase_d;
            prev_s_q <= bus.s;
            prev_a_q <= bus.a;
            err_q    <= err_d;
            code_q   <= code_d;
            got_q    <= got_d;
            exp_q    <= exp_d;
        end
    end

    assign bus.err      = err_q;
    assign bus.err_code = code_q;
    assign bus.err_got  = got_q;
    assign bus.err_exp  = exp_q;

    sat_counter #(.W(CNT_W)) u_trans_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (trans_inc),
        .q     (bus.trans_cnt)
    );

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hit_inc),
        .q     (bus.hit_cnt)
    );
endmodule

// File: tb/tb_fsm_trace_monitor.sv
// Bench for fsm_trace_monitor: two instances (8-bit and 3-bit counters)
// observe the same a/s trace; a behavioural model of the FSM's legal
// transitions predicts every output.
module tb_fsm_trace_monitor;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a = 1'b0;
    logic [2:0] s = 3'd2;

    int total = 0;
    int bad = 0;

    fsm_trace_monitor_if #(.CNT_W(8)) bus8 ();
    fsm_trace_monitor_if #(.CNT_W(3)) bus3 ();

    assign bus8.a = a;
    assign bus8.s = s;
    assign bus3.a = a;
    assign bus3.s = s;

    fsm_trace_monitor #(.CNT_W(8), .WATCH(3'd7)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    fsm_trace_monitor #(.CNT_W(3), .WATCH(3'd7)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    always #5 clk = ~clk;

    // Successor tables indexed by current state, one per value of a.
    logic [2:0] succ_a0 [8] = '{3'd0, 3'd1, 3'd4, 3'd3, 3'd6, 3'd2, 3'd5, 3'd6};
    logic [2:0] succ_a1 [8] = '{3'd0, 3'd1, 3'd4, 3'd3, 3'd7, 3'd4, 3'd5, 3'd6};

    // Reference model state
    bit         m_first = 1'b1;
    logic [2:0] m_prev_s = 3'd0;
    logic       m_prev_a = 1'b0;
    logic       m_err = 1'b0;
    logic [1:0] m_code = 2'd0;
    logic [2:0] m_got = 3'd0;
    logic [2:0] m_exp = 3'd0;
    int         m_trans = 0;
    int         m_hit = 0;

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    function automatic logic [2:0] model_next();
        if (m_first) return 3'd2;
        return m_prev_a ? succ_a1[m_prev_s] : succ_a0[m_prev_s];
    endfunction

    task automatic note_error(input logic [1:0] code, input logic [2:0] got,
                              input logic [2:0] expv);
        if (!m_err) begin
            m_err  = 1'b1;
            m_code = code;
            m_got  = got;
            m_exp  = expv;
        end
    endtask

    // Drive one cycle of stimulus, advance the model across the edge, then
    // leave time just after the edge for sampling.
    task automatic step(input logic ia, input logic [2:0] is, input logic ir);
        logic [2:0] want;
        bit         illegal;
        @(negedge clk);
        a = ia;
        s = is;
        reset = ir;
        @(posedge clk);
        illegal = (is == 3'd0) || (is == 3'd1) || (is == 3'd3);
        if (ir) begin
            m_first = 1'b1; m_prev_s = 3'd0; m_prev_a = 1'b0;
            m_err = 1'b0; m_code = 2'd0; m_got = 3'd0; m_exp = 3'd0;
            m_trans = 0; m_hit = 0;
        end else begin
            if (m_first) begin
                if (is != 3'd2) note_error(2'b11, is, 3'd2);
                if (is == 3'd7) m_hit++;
            end else begin
                want = model_next();
                if (illegal) note_error(2'b01, is, 3'd0);
                else if (is != want) note_error(2'b10, is, want);
                m_trans++;
                if (is == 3'd7 && m_prev_s != 3'd7) m_hit++;
            end
            m_first = 1'b0;
            m_prev_s = is;
            m_prev_a = ia;
        end
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 3'd2, 1'b1);
        step(1'b0, 3'd2, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus8.err !== 1'b0) begin bad++;
            $display("FAIL reset_err: got %0d want 0", bus8.err); end
        total++; if (bus8.err_code !== 2'd0) begin bad++;
            $display("FAIL reset_code: got %0d want 0", bus8.err_code); end
        total++; if (bus8.err_got !== 3'd0 || bus8.err_exp !== 3'd0) begin bad++;
            $display("FAIL reset_capture: got %0d/%0d want 0/0", bus8.err_got, bus8.err_exp); end
        total++; if (bus8.trans_cnt !== 8'd0 || bus8.hit_cnt !== 8'd0) begin bad++;
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus8.trans_cnt, bus8.hit_cnt); end
        total++; if (bus3.trans_cnt !== 3'd0 || bus3.err !== 1'b0) begin bad++;
            $display("FAIL reset_cnt3: got %0d/%0d want 0/0", bus3.trans_cnt, bus3.err); end
    endtask

    task automatic test_a0_path();
        logic [2:0] seq [6] = '{3'd2, 3'd4, 3'd6, 3'd5, 3'd2, 3'd4};
        do_reset();
        foreach (seq[i]) begin
            step(1'b0, seq[i], 1'b0);
            total++; if (bus8.err !== 1'b0) begin bad++;
                $display("FAIL a0_err[%0d]: got %0d want 0", i, bus8.err); end
        end
        total++; if (bus8.trans_cnt !== 8'd5) begin bad++;
            $display("FAIL a0_trans: got %0d want 5", bus8.trans_cnt); end
        total++; if (bus8.hit_cnt !== 8'd0) begin bad++;
            $display("FAIL a0_hit: got %0d want 0", bus8.hit_cnt); end
    endtask

    task automatic test_a1_path();
        logic [2:0] seq [7] = '{3'd2, 3'd4, 3'd7, 3'd6, 3'd5, 3'd4, 3'd7};
        do_reset();
        foreach (seq[i]) step(1'b1, seq[i], 1'b0);
        total++; if (bus8.err !== 1'b0) begin bad++;
            $display("FAIL a1_err: got %0d want 0 (code %0d)", bus8.err, bus8.err_code); end
        total++; if (bus8.hit_cnt !== 8'd2) begin bad++;
            $display("FAIL a1_hit: got %0d want 2", bus8.hit_cnt); end
        total++; if (bus8.trans_cnt !== 8'd6) begin bad++;
            $display("FAIL a1_trans: got %0d want 6", bus8.trans_cnt); end
    endtask

    task automatic test_wrong_transition();
        do_reset();
        step(1'b0, 3'd2, 1'b0);
        step(1'b0, 3'd4, 1'b0);
        step(1'b0, 3'd7, 1'b0);
        total++; if (bus8.err !== 1'b1 || bus8.err_code !== 2'b10) begin bad++;
            $display("FAIL wrong_code: got err=%0d code=%0d want 1/2", bus8.err, bus8.err_code); end
        total++; if (bus8.err_got !== 3'd7 || bus8.err_exp !== 3'd6) begin bad++;
            $display("FAIL wrong_capture: got %0d/%0d want 7/6", bus8.err_got, bus8.err_exp); end
        step(1'b0, 3'd1, 1'b0);
        total++; if (bus8.err_code !== 2'b10 || bus8.err_got !== 3'd7 || bus8.err_exp !== 3'd6)
        begin bad++;
            $display("FAIL sticky_capture: got %0d/%0d/%0d want 2/7/6",
                     bus8.err_code, bus8.err_got, bus8.err_exp); end
        total++; if (bus8.trans_cnt !== 8'd3) begin bad++;
            $display("FAIL trans_after_err: got %0d want 3", bus8.trans_cnt); end
    endtask

    task automatic test_illegal_and_bad_reset();
        do_reset();
        step(1'b0, 3'd2, 1'b0);
        step(1'b0, 3'd3, 1'b0);
        total++; if (bus8.err_code !== 2'b01 || bus8.err_got !== 3'd3 || bus8.err_exp !== 3'd0)
        begin bad++;
            $display("FAIL illegal_capture: got %0d/%0d/%0d want 1/3/0",
                     bus8.err_code, bus8.err_got, bus8.err_exp); end
        do_reset();
        step(1'b0, 3'd5, 1'b0);
        total++; if (bus8.err_code !== 2'b11 || bus8.err_got !== 3'd5 || bus8.err_exp !== 3'd2)
        begin bad++;
            $display("FAIL bad_reset_capture: got %0d/%0d/%0d want 3/5/2",
                     bus8.err_code, bus8.err_got, bus8.err_exp); end
        do_reset();
        step(1'b0, 3'd0, 1'b0);
        total++; if (bus8.err_code !== 2'b11 || bus8.err_exp !== 3'd2) begin bad++;
            $display("FAIL idle_illegal: got %0d/%0d want 3/2", bus8.err_code, bus8.err_exp); end
    endtask

    task automatic test_saturation();
        logic [2:0] loop4 [4] = '{3'd2, 3'd4, 3'd6, 3'd5};
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, loop4[i % 4], 1'b0);
        total++; if (bus3.trans_cnt !== 3'd7) begin bad++;
            $display("FAIL sat_trans3: got %0d want 7", bus3.trans_cnt); end
        total++; if (bus8.trans_cnt !== 8'd19) begin bad++;
            $display("FAIL sat_trans8: got %0d want 19", bus8.trans_cnt); end
        total++; if (bus3.err !== 1'b0) begin bad++;
            $display("FAIL sat_err: got %0d want 0", bus3.err); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        step(1'b1, 3'd2, 1'b0);
        step(1'b1, 3'd4, 1'b0);
        step(1'b1, 3'd7, 1'b0);
        step(1'b1, 3'd5, 1'b0);
        step(1'b0, 3'd5, 1'b1);
        total++; if ({bus8.err, bus8.err_code, bus8.err_got, bus8.err_exp} !== 9'd0) begin bad++;
            $display("FAIL midreset_err: got %0d/%0d/%0d/%0d want 0",
                     bus8.err, bus8.err_code, bus8.err_got, bus8.err_exp); end
        total++; if (bus8.trans_cnt !== 8'd0 || bus8.hit_cnt !== 8'd0) begin bad++;
            $display("FAIL midreset_cnt: got %0d/%0d want 0/0", bus8.trans_cnt, bus8.hit_cnt); end
        step(1'b0, 3'd2, 1'b0);
        step(1'b0, 3'd4, 1'b0);
        total++; if (bus8.err !== 1'b0 || bus8.trans_cnt !== 8'd1) begin bad++;
            $display("FAIL midreset_resume: got err=%0d trans=%0d want 0/1",
                     bus8.err, bus8.trans_cnt); end
    endtask

    task automatic test_random();
        logic [2:0] ns;
        logic       na;
        logic       nr;
        logic [7:0] e_t8, e_h8;
        logic [2:0] e_t3, e_h3;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            na = ($urandom_range(0, 3) != 0);
            nr = ($urandom_range(0, 99) < 2);
            ns = ($urandom_range(0, 99) < 8) ? 3'($urandom_range(0, 7)) : model_next();
            step(na, ns, nr);
            e_t8 = 8'(sat(m_trans, 255));
            e_h8 = 8'(sat(m_hit, 255));
            e_t3 = 3'(sat(m_trans, 7));
            e_h3 = 3'(sat(m_hit, 7));
            total++;
            if (bus8.err !== m_err || bus8.err_code !== m_code || bus8.err_got !== m_got ||
                bus8.err_exp !== m_exp) begin
                bad++;
                $display("FAIL rnd_err[%0d]: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", i,
                         bus8.err, bus8.err_code, bus8.err_got, bus8.err_exp,
                         m_err, m_code, m_got, m_exp);
            end
            total++;
            if (bus8.trans_cnt !== e_t8 || bus8.hit_cnt !== e_h8) begin
                bad++;
                $display("FAIL rnd_cnt8[%0d]: got %0d/%0d want %0d/%0d", i,
                         bus8.trans_cnt, bus8.hit_cnt, e_t8, e_h8);
            end
            total++;
            if (bus3.trans_cnt !== e_t3 || bus3.hit_cnt !== e_h3 || bus3.err !== m_err) begin
                bad++;
                $display("FAIL rnd_cnt3[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                         bus3.trans_cnt, bus3.hit_cnt, bus3.err, e_t3, e_h3, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_a0_path();
        test_a1_path();
        test_wrong_transition();
        test_illegal_and_bad_reset();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
